rob_retire: RTL and testbench
=============================

Name: rob_retire

Overview:
- In-order reorder buffer with retire stage: allocates entries at rename/dispatch, records completion by tag, retires up to W oldest completed entries per cycle.
- Retire outputs drive the architectural RAT: retire_valid, retire_dest_arn, retire_dest_prn.
- retire_old_prn goes to the free list.
- Squashes younger entries on branch mispredict.

Parameters:
- DEPTH, 32, ROB entries; power of two.
- W, 4, dispatch/complete/retire width (MACHINE_WIDTH).
- ARF_WIDTH, 5, architectural register index width.
- PRF_WIDTH, 6, physical register index width.
- TAG_W, log2(DEPTH), ROB tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dispatch_valid  in  W  per-slot allocate request; contiguous prefix (slot i set implies slots 0..i-1 set)
- dispatch_has_dest  in  W  slot writes a register
- dispatch_arn  in  W x ARF_WIDTH  destination arch reg
- dispatch_prn  in  W x PRF_WIDTH  new physical reg
- dispatch_old_prn  in  W x PRF_WIDTH  previous mapping of arn
- dispatch_ready  out  1  at least W entries free and no mispredict this cycle
- dispatch_tag  out  W x TAG_W  tag for slot i = tail+i mod DEPTH (combinational)
- complete_valid  in  W  completion strobes
- complete_tag  in  W x TAG_W  completing entry tags
- br_mispredict  in  1  squash all entries younger than br_tag
- br_tag  in  TAG_W  mispredicting branch tag; must be in flight
- retire_valid  out  W  contiguous prefix of retiring slots
- retire_dest_arn  out  W x ARF_WIDTH  0 when entry has no destination
- retire_dest_prn  out  W x PRF_WIDTH  committed physical reg
- retire_old_prn  out  W x PRF_WIDTH  reg to free; meaningful only when has_dest
- retire_free_valid  out  W  retire_valid[i] & has_dest
- rob_empty  out  1  no valid entries
- rob_full  out  1  count == DEPTH

Behaviour:
- State: head and tail pointers, each TAG_W+1 bits with a wrap bit; count = tail - head.
- Per entry: valid, complete, has_dest, arn, prn, old_prn.
- Reset (async):
  - head = tail = 0; all entries invalid.
  - retire_valid = 0; retire_free_valid = 0; rob_empty = 1; rob_full = 0; dispatch_ready = 1.
- Dispatch:
  - Accepted only when dispatch_ready.
  - Slot i writes entry tail+i with valid=1, complete=0.
  - tail += popcount(dispatch_valid).
  - dispatch_valid while not ready is ignored; upstream holds it.
- Completion:
  - Sets complete on the target entry at the clock edge, only if that entry is valid.
  - Duplicate tags in one cycle are legal.
  - An entry completed in cycle N can retire in cycle N+1 at the earliest (no same-cycle bypass).
- Retire (combinational outputs from entries head..head+W-1):
  - Slot i retires iff entries head..head+i are all valid and complete.
  - Outputs are the entry fields; arn is forced to 0 when !has_dest.
  - At the edge: head += retire count; retired entries are invalidated.
- Mispredict:
  - At the edge: tail = br_tag+1 with the correct wrap bit; entries br_tag+1 .. old tail-1 are invalidated.
  - The same cycle forces dispatch_ready = 0, so no allocation occurs.
  - Completions in that cycle targeting squashed entries are dropped.
  - Retirement of entries up to and including br_tag proceeds normally in the same cycle.
- Wrap-around: tags index modulo DEPTH; full vs empty is distinguished by the wrap bit.
- rob_full and rob_empty are registered-state derived, i.e. comb from the pointers.
- Reset mid-operation discards all entries immediately; outputs return to reset values asynchronously.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- When defined:
  - Adds output perf_retired (32 bits) and perf_stall (32 bits).
  - perf_retired += retire count each cycle.
  - perf_stall += 1 when dispatch_valid[0] & !dispatch_ready.
  - Both counters reset to 0, wrap modulo 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then dispatch 4 slots with arn 1,2,0(no dest),3 and prn 10,11,12,13 → tags 0..3; rob_empty=0 next cycle.
- Complete tags 1,2,3 only → no retire. Complete tag 0 → next cycle retire_valid=4'b1111, arn 1,2,0,3, prn 10,11,12,13, retire_free_valid=4'b1011.
- Fill to 32 entries → rob_full=1, dispatch_ready=0 when count>28. Retire 4 → ready returns; tags wrap 31→0 correctly.
- With 10 entries in flight at tags 0..9, br_mispredict with br_tag=4 plus concurrent completion of tag 7 → tail=5, tag 7 never retires, next dispatch_tag[0]=5.
- Entries 0,1 complete plus mispredict on tag 1 in the same cycle → retire_valid=4'b0011 that cycle; rob_empty=1 next cycle.
- With ROB_PERF_CNT_EN: 3 stalled dispatch cycles and 8 retirements → perf_stall=3, perf_retired=8.

Source files
------------

// File: rtl/rob_retire_if.sv
// Dispatch, completion, branch-squash and retire bundle between the pipeline and the ROB.
// The master side is the pipeline; the slave side is the reorder buffer.
interface rob_retire_if #(
    parameter int unsigned W         = 4,
    parameter int unsigned ARF_WIDTH = 5,
    parameter int unsigned PRF_WIDTH = 6,
    parameter int unsigned TAG_W     = 5
);
    logic [W-1:0]                dispatch_valid;
    logic [W-1:0]                dispatch_has_dest;
    logic [W-1:0][ARF_WIDTH-1:0] dispatch_arn;
    logic [W-1:0][PRF_WIDTH-1:0] dispatch_prn;
    logic [W-1:0][PRF_WIDTH-1:0] dispatch_old_prn;
    logic                        dispatch_ready;
    logic [W-1:0][TAG_W-1:0]     dispatch_tag;
    logic [W-1:0]                complete_valid;
    logic [W-1:0][TAG_W-1:0]     complete_tag;
    logic                        br_mispredict;
    logic [TAG_W-1:0]            br_tag;
    logic [W-1:0]                retire_valid;
    logic [W-1:0][ARF_WIDTH-1:0] retire_dest_arn;
    logic [W-1:0][PRF_WIDTH-1:0] retire_dest_prn;
    logic [W-1:0][PRF_WIDTH-1:0] retire_old_prn;
    logic [W-1:0]                retire_free_valid;
    logic                        rob_empty;
    logic                        rob_full;

    modport master (
        output dispatch_valid, dispatch_has_dest, dispatch_arn, dispatch_prn, dispatch_old_prn,
        output complete_valid, complete_tag, br_mispredict, br_tag,
        input  dispatch_ready, dispatch_tag,
        input  retire_valid, retire_dest_arn, retire_dest_prn, retire_old_prn, retire_free_valid,
        input  rob_empty, rob_full
    );

    modport slave (
        input  dispatch_valid, dispatch_has_dest, dispatch_arn, dispatch_prn, dispatch_old_prn,
        input  complete_valid, complete_tag, br_mispredict, br_tag,
        output dispatch_ready, dispatch_tag,
        output retire_valid, retire_dest_arn, retire_dest_prn, retire_old_prn, retire_free_valid,
        output rob_empty, rob_full
    );
endinterface

// File: rtl/rob_retire.sv
// In-order reorder buffer: W-wide allocate, complete-by-tag, in-order retire, branch squash.
// Optional ROB_PERF_CNT_EN adds perf_retired / perf_stall counters.
module rob_retire #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned W         = 4,
    parameter int unsigned ARF_WIDTH = 5,
    parameter int unsigned PRF_WIDTH = 6,
    parameter int unsigned TAG_W     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    rob_retire_if.slave rob
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall
`endif
);
    localparam int unsigned PTR_W  = TAG_W + 1;
    localparam int unsigned WCNT_W = $clog2(W + 1);

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]     count, free_cnt;
    logic [DEPTH-1:0]     valid_q, valid_d, complete_q, complete_d, has_dest_q, has_dest_d;
    logic [ARF_WIDTH-1:0] arn_q     [DEPTH];
    logic [ARF_WIDTH-1:0] arn_d     [DEPTH];
    logic [PRF_WIDTH-1:0] prn_q     [DEPTH];
    logic [PRF_WIDTH-1:0] prn_d     [DEPTH];
    logic [PRF_WIDTH-1:0] old_prn_q [DEPTH];
    logic [PRF_WIDTH-1:0] old_prn_d [DEPTH];

    logic                    ready_c;
    logic [W-1:0][TAG_W-1:0] disp_idx, ret_idx;
    logic [W-1:0]            ret_vec;
    logic [WCNT_W-1:0]       ret_cnt;
    logic [TAG_W-1:0]        br_off;
    logic                    chain;

    // Wrap bit makes tail - head range over 0..DEPTH, separating full from empty.
    assign count    = tail_q - head_q;
    assign free_cnt = PTR_W'(DEPTH) - count;
    assign ready_c  = (free_cnt >= PTR_W'(W)) && !rob.br_mispredict;
    assign br_off   = rob.br_tag - head_q[TAG_W-1:0];

    always_comb begin
        for (int unsigned i = 0; i < W; i++) begin
            disp_idx[i] = tail_q[TAG_W-1:0] + TAG_W'(i);
            ret_idx[i]  = head_q[TAG_W-1:0] + TAG_W'(i);
        end
    end

    // Oldest-first retire chain; a mispredict stops it just past the branch.
    always_comb begin
        ret_vec = '0;
        ret_cnt = '0;
        chain   = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            chain = chain && valid_q[ret_idx[i]] && complete_q[ret_idx[i]]
                    && !(rob.br_mispredict && (TAG_W'(i) > br_off));
            ret_vec[i] = chain;
            ret_cnt    = ret_cnt + WCNT_W'(chain);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < W; i++) begin
            rob.retire_dest_arn[i]   = has_dest_q[ret_idx[i]] ? arn_q[ret_idx[i]] : '0;
            rob.retire_dest_prn[i]   = prn_q[ret_idx[i]];
            rob.retire_old_prn[i]    = old_prn_q[ret_idx[i]];
            rob.retire_free_valid[i] = ret_vec[i] && has_dest_q[ret_idx[i]];
        end
    end

    assign rob.retire_valid   = ret_vec;
    assign rob.dispatch_ready = ready_c;
    assign rob.dispatch_tag   = disp_idx;
    assign rob.rob_empty      = (head_q == tail_q);
    assign rob.rob_full       = (count == PTR_W'(DEPTH));

    // Later updates override earlier ones: complete, retire, allocate, squash.
    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        has_dest_d = has_dest_q;
        arn_d      = arn_q;
        prn_d      = prn_q;
        old_prn_d  = old_prn_q;
        head_d     = head_q + PTR_W'(ret_cnt);
        tail_d     = tail_q;

        for (int unsigned i = 0; i < W; i++) begin
            if (rob.complete_valid[i] && valid_q[rob.complete_tag[i]]) begin
                complete_d[rob.complete_tag[i]] = 1'b1;
            end
        end

        for (int unsigned i = 0; i < W; i++) begin
            if (ret_vec[i]) begin
                valid_d[ret_idx[i]]    = 1'b0;
                complete_d[ret_idx[i]] = 1'b0;
            end
        end

        if (ready_c) begin
            tail_d = tail_q + PTR_W'($countones(rob.dispatch_valid));
            for (int unsigned i = 0; i < W; i++) begin
                if (rob.dispatch_valid[i]) begin
                    valid_d[disp_idx[i]]    = 1'b1;
                    complete_d[disp_idx[i]] = 1'b0;
                    has_dest_d[disp_idx[i]] = rob.dispatch_has_dest[i];
                    arn_d[disp_idx[i]]      = rob.dispatch_arn[i];
                    prn_d[disp_idx[i]]      = rob.dispatch_prn[i];
                    old_prn_d[disp_idx[i]]  = rob.dispatch_old_prn[i];
                end
            end
        end

        if (rob.br_mispredict) begin
            tail_d = head_q + PTR_W'(br_off) + PTR_W'(1);
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((TAG_W'(j) - head_q[TAG_W-1:0]) > br_off) begin
                    valid_d[j]    = 1'b0;
                    complete_d[j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            complete_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        has_dest_q <= has_dest_d;
        arn_q      <= arn_d;
        prn_q      <= prn_d;
        old_prn_q  <= old_prn_d;
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_retired_q, perf_retired_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_retired_d = perf_retired_q + 32'(ret_cnt);
        perf_stall_d   = perf_stall_q + 32'(rob.dispatch_valid[0] && !ready_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: vector table plus hand-written fill/wrap, squash and reset sequences.
// Retired payloads are checked against a scoreboard queue filled at dispatch time.
module tb_rob_retire;
    logic clk;
    logic rst_n;

    rob_retire_if #(.W(4), .ARF_WIDTH(5), .PRF_WIDTH(6), .TAG_W(5)) rob_if ();

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_retired, perf_stall;
`endif

    rob_retire #(.DEPTH(32), .W(4), .ARF_WIDTH(5), .PRF_WIDTH(6), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (rob_if)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] arn;
        logic [5:0] prn;
        logic [5:0] old;
        logic       hd;
    } exp_t;

    typedef struct {
        logic [3:0]  dv;
        logic [3:0]  hd;
        logic [19:0] arn;
        logic [23:0] prn;
        logic [23:0] old;
        logic [3:0]  cv;
        logic [19:0] ctag;
        logic [3:0]  e_rv;
        logic [3:0]  e_free;
        logic        e_ready;
        logic        e_empty;
        logic [4:0]  e_tag0;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Retired slots must match the oldest outstanding dispatches, in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (rob_if.retire_valid[i]) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected_retire: slot %0d prn %0d with no outstanding entry",
                                 i, rob_if.retire_dest_prn[i]);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_arn", 32'(rob_if.retire_dest_arn[i]), 32'(e.arn));
                        chk("sb_prn", 32'(rob_if.retire_dest_prn[i]), 32'(e.prn));
                        chk("sb_free", 32'(rob_if.retire_free_valid[i]), 32'(e.hd));
                        if (e.hd) chk("sb_old_prn", 32'(rob_if.retire_old_prn[i]), 32'(e.old));
                    end
                end
            end
        end
    end

    task automatic set_idle();
        rob_if.dispatch_valid    = '0;
        rob_if.dispatch_has_dest = '0;
        rob_if.dispatch_arn      = '0;
        rob_if.dispatch_prn      = '0;
        rob_if.dispatch_old_prn  = '0;
        rob_if.complete_valid    = '0;
        rob_if.complete_tag      = '0;
        rob_if.br_mispredict     = 1'b0;
        rob_if.br_tag            = '0;
    endtask

    task automatic disp(input logic [3:0] dv, input logic [3:0] hd, input logic [19:0] arn,
                        input logic [23:0] prn, input logic [23:0] old, input bit push);
        rob_if.dispatch_valid    = dv;
        rob_if.dispatch_has_dest = hd;
        rob_if.dispatch_arn      = arn;
        rob_if.dispatch_prn      = prn;
        rob_if.dispatch_old_prn  = old;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (dv[i]) sb.push_back('{arn: hd[i] ? arn[i*5 +: 5] : 5'd0, prn: prn[i*6 +: 6],
                                          old: old[i*6 +: 6], hd: hd[i]});
            end
        end
    endtask

    task automatic cmp(input logic [3:0] cv, input logic [19:0] ctag);
        rob_if.complete_valid = cv;
        rob_if.complete_tag   = ctag;
    endtask

    // Check outputs mid-cycle, then take the clock edge and return inputs to idle.
    task automatic step_chk(input string name, input logic [3:0] rv, input logic [3:0] free,
                            input logic rdy, input logic emp, input logic full, input logic [4:0] tag0);
        logic [19:0] tags;
        for (int i = 0; i < 4; i++) tags[i*5 +: 5] = tag0 + 5'(i);
        @(negedge clk);
        chk({name, ".retire_valid"}, 32'(rob_if.retire_valid), 32'(rv));
        chk({name, ".free_valid"}, 32'(rob_if.retire_free_valid), 32'(free));
        chk({name, ".ready"}, 32'(rob_if.dispatch_ready), 32'(rdy));
        chk({name, ".empty"}, 32'(rob_if.rob_empty), 32'(emp));
        chk({name, ".full"}, 32'(rob_if.rob_full), 32'(full));
        chk({name, ".tags"}, 32'(rob_if.dispatch_tag), 32'(tags));
        @(posedge clk);
        #1;
        set_idle();
    endtask

    function automatic vec_t mkv(input logic [3:0] dv, input logic [3:0] hd, input logic [19:0] arn,
                                 input logic [23:0] prn, input logic [3:0] cv, input logic [19:0] ctag,
                                 input logic [3:0] e_rv, input logic [3:0] e_free, input logic e_ready,
                                 input logic e_empty, input logic [4:0] e_tag0);
        vec_t v;
        v.dv = dv; v.hd = hd; v.arn = arn; v.prn = prn; v.cv = cv; v.ctag = ctag;
        v.e_rv = e_rv; v.e_free = e_free; v.e_ready = e_ready; v.e_empty = e_empty; v.e_tag0 = e_tag0;
        for (int i = 0; i < 4; i++) v.old[i*6 +: 6] = prn[i*6 +: 6] + 6'd20;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[14];
        logic [19:0] arn_v, tags_v;
        logic [23:0] prn_v, old_v;
        logic [4:0]  t;

        vt[0]  = mkv(4'b1111, 4'b1011, {5'd3, 5'd7, 5'd2, 5'd1}, {6'd13, 6'd12, 6'd11, 6'd10},
                     4'b0000, 20'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        vt[1]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd4);
        vt[2]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0111, {5'd0, 5'd3, 5'd2, 5'd1},
                     4'b0000, 4'b0000, 1'b1, 1'b0, 5'd4);
        vt[3]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd4);
        vt[4]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0001, 20'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd4);
        vt[5]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b1111, 4'b1011, 1'b1, 1'b0, 5'd4);
        vt[6]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd4);
        vt[7]  = mkv(4'b0011, 4'b0011, {5'd0, 5'd0, 5'd6, 5'd5}, {6'd0, 6'd0, 6'd31, 6'd30},
                     4'b0011, {5'd0, 5'd0, 5'd4, 5'd4}, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd4);
        vt[8]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd6);
        vt[9]  = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0011, {5'd0, 5'd0, 5'd4, 5'd4},
                     4'b0000, 4'b0000, 1'b1, 1'b0, 5'd6);
        vt[10] = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b0001, 4'b0001, 1'b1, 1'b0, 5'd6);
        vt[11] = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5},
                     4'b0000, 4'b0000, 1'b1, 1'b0, 5'd6);
        vt[12] = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b0001, 4'b0001, 1'b1, 1'b0, 5'd6);
        vt[13] = mkv(4'b0, 4'b0, 20'd0, 24'd0, 4'b0000, 20'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd6);

        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
`ifdef ROB_PERF_CNT_EN
        chk("reset.perf_retired", perf_retired, 32'd0);
        chk("reset.perf_stall", perf_stall, 32'd0);
`endif
        step_chk("reset", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd0);
        rst_n = 1'b1;

        // Table: basic dispatch, out-of-order completion, dropped and duplicate completions.
        for (int k = 0; k < 14; k++) begin
            disp(vt[k].dv, vt[k].hd, vt[k].arn, vt[k].prn, vt[k].old, vt[k].e_ready);
            cmp(vt[k].cv, vt[k].ctag);
            step_chk($sformatf("vec%0d", k), vt[k].e_rv, vt[k].e_free, vt[k].e_ready,
                     vt[k].e_empty, 1'b0, vt[k].e_tag0);
        end

        // Fill from tag 6 to 32 entries; tags wrap 31 -> 0 in the seventh group.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                arn_v[i*5 +: 5] = 5'(4*k + i + 1);
                prn_v[i*6 +: 6] = 6'(4*k + i + 8);
                old_v[i*6 +: 6] = 6'(4*k + i + 40);
            end
            disp(4'b1111, 4'b1111, arn_v, prn_v, old_v, 1'b1);
            step_chk($sformatf("fill%0d", k), 4'b0000, 4'b0000, 1'b1, (k == 0), 1'b0, 5'(6 + 4*k));
        end
        disp(4'b1111, 4'b1111, 20'hfffff, 24'hffffff, 24'hffffff, 1'b0);
        step_chk("full_ignored", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 5'd6);

        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                for (int i = 0; i < 4; i++) begin
                    t = 5'(6 + 4*k + i);
                    tags_v[i*5 +: 5] = t;
                end
                cmp(4'b1111, tags_v);
            end
            if (k == 0)      step_chk("drain0", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 5'd6);
            else if (k == 1) step_chk("drain1", 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 5'd6);
            else if (k < 9)  step_chk($sformatf("drain%0d", k), 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 5'd6);
            else             step_chk("drain9", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd6);
        end
        chk("fill.sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset with entries in flight.
        disp(4'b1111, 4'b0101, 20'h12345, 24'h123456, 24'h654321, 1'b1);
        step_chk("pre_reset", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd6);
        chk("pre_reset.empty", 32'(rob_if.rob_empty), 32'd0);
`ifdef ROB_PERF_CNT_EN
        chk("pre_reset.perf_retired", perf_retired, 32'd38);
        chk("pre_reset.perf_stall", perf_stall, 32'd1);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset.empty", 32'(rob_if.rob_empty), 32'd1);
        chk("async_reset.retire_valid", 32'(rob_if.retire_valid), 32'd0);
        chk("async_reset.ready", 32'(rob_if.dispatch_ready), 32'd1);
        chk("async_reset.tag0", 32'(rob_if.dispatch_tag[0]), 32'd0);
`ifdef ROB_PERF_CNT_EN
        chk("async_reset.perf_retired", perf_retired, 32'd0);
`endif
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Ten entries at tags 0..9, squash after tag 4 with a completion to squashed tag 7.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                arn_v[i*5 +: 5] = 5'(4*k + i + 10);
                prn_v[i*6 +: 6] = 6'(4*k + i + 20);
                old_v[i*6 +: 6] = 6'(4*k + i + 50);
            end
            disp((k == 2) ? 4'b0011 : 4'b1111, 4'b1110, arn_v, prn_v, old_v, 1'b1);
            step_chk($sformatf("sq_fill%0d", k), 4'b0000, 4'b0000, 1'b1, (k == 0), 1'b0, 5'(4*k));
        end
        rob_if.br_mispredict = 1'b1;
        rob_if.br_tag        = 5'd4;
        cmp(4'b0001, {5'd0, 5'd0, 5'd0, 5'd7});
        disp(4'b1111, 4'b1111, 20'd0, 24'd0, 24'd0, 1'b0);
        step_chk("squash", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd10);
        repeat (5) void'(sb.pop_back());
        cmp(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0});
        step_chk("squash+1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd5);
        cmp(4'b0011, {5'd0, 5'd0, 5'd7, 5'd4});
        step_chk("squash+2", 4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0, 5'd5);
        step_chk("squash+3", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd5);
        step_chk("squash+4", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd5);

        // Mispredict on tag 6 while 5,6,7 are complete: only 5 and 6 retire.
        disp(4'b1111, 4'b1111, {5'd30, 5'd29, 5'd28, 5'd27}, {6'd63, 6'd62, 6'd61, 6'd60},
             {6'd3, 6'd2, 6'd1, 6'd0}, 1'b1);
        step_chk("br_ret0", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd5);
        cmp(4'b0111, {5'd0, 5'd7, 5'd6, 5'd5});
        step_chk("br_ret1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd9);
        rob_if.br_mispredict = 1'b1;
        rob_if.br_tag        = 5'd6;
        step_chk("br_ret2", 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0, 5'd9);
        repeat (2) void'(sb.pop_back());
        step_chk("br_ret3", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd7);
        chk("end.sb_drained", 32'(sb.size()), 32'd0);
`ifdef ROB_PERF_CNT_EN
        chk("end.perf_retired", perf_retired, 32'd7);
        chk("end.perf_stall", perf_stall, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
